tdm_demux4: RTL and testbench
=============================

Name: tdm_demux4

Overview:
- Receive-side time-division demultiplexer that undoes a 4:1 slot multiplexer.
- A single time-shared data line carries one slot per enabled clock. A frame_sync strobe marks slot 0.
- The block steers each slot into its channel, then presents a complete parallel frame with a valid/ready handshake.
- It sits between a serial TDM link and the per-channel consumers, as the counterpart to the 4:1 mux select logic.

Parameters:
- CH, 4, number of slots per frame; must be a power of two, at least 2.
- W, 1, bits per slot (data width of din and of each channel).
- SEL_W, $clog2(CH), width of the slot index.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  slot strobe; a sample is taken only when en=1.
- din  in  W  time-shared slot data.
- frame_sync  in  1  qualified by en; marks din as slot 0.
- q  out  CH*W  demultiplexed frame; channel k is q[k*W +: W].
- out_valid  out  1  q holds an unconsumed frame.
- out_ready  in  1  consumer accepts the frame when out_valid=1 and out_ready=1.
- slot  out  SEL_W  index the next enabled sample will be written to.
- locked  out  1  1 in RUN state.
- sync_err  out  1  1-cycle pulse: frame_sync seen at a nonzero slot while in RUN.
- overrun  out  1  1-cycle pulse: a new frame overwrote an unconsumed frame.

Behaviour:
- Reset (rst=1 at a rising edge) forces all of the following, regardless of other inputs:
  - q=0, out_valid=0, slot=0, locked=0, sync_err=0, overrun=0.
  - Shadow register cleared; state=HUNT.
- States:
  - HUNT: enabled samples are ignored until en=1 with frame_sync=1. That sample is stored as shadow[0], slot becomes 1 and the state goes to RUN.
  - RUN: each en=1 sample is stored as shadow[slot]; slot increments modulo CH (wraps CH-1 -> 0).
- en=0: nothing is captured and slot and state hold. en gaps inside a frame are legal.
- Frame completion: at the edge where en=1 and slot=CH-1 in RUN:
  - q is loaded with shadow[0..CH-2] plus the current din as channel CH-1, all in the same edge.
  - out_valid=1 after that edge, so latency from last slot sample to visible frame is one edge.
- Handshake:
  - out_valid stays high and q stays stable until the consumer accepts (out_valid=1 and out_ready=1); out_valid then clears on the next edge.
  - If acceptance and a new frame completion happen on the same edge, q loads the new frame and out_valid stays 1. No overrun is raised.
  - If a frame completes while out_valid=1 and out_ready=0, q is overwritten, out_valid stays 1 and overrun pulses for one cycle.
- Resync rules in RUN:
  - en=1, frame_sync=1 and slot!=0: sync_err pulses for one cycle.
  - The partial frame is discarded; the current sample becomes shadow[0] and slot becomes 1. The state stays RUN and q/out_valid are untouched.
  - frame_sync=1 at slot=0 is the normal case, with no error.
  - frame_sync=0 at slot=0 is accepted without error (free-running frames).
  - frame_sync is ignored when en=0.
- Special case CH-1 with frame_sync=1: this is a resync, not a completion; no frame is emitted.
- Reset mid-frame: the partial frame is lost and out_valid drops on the reset edge. The block returns to HUNT and must see frame_sync again.
- The shadow register holds CH-1 slots; the last slot goes straight to q.
- All outputs are registered. There is no combinational path from inputs to outputs.

Decomposition:
- Shared package tdm_pkg:
  - State enum (HUNT, RUN).
  - Default CH/W constants.
  - A helper function giving the channel bit offset (k*W).
- Natural sub-module: tdm_slot_counter. Modulo-CH counter with en, synchronous load-to-1 (resync/lock) and a terminal-count flag (slot==CH-1).
- Shadow storage, output register and handshake stay in tdm_demux4.

Test Plan:
- Lock and frame (CH=4, W=1): rst 2 cycles, then en=1 with din=1,0,1,1 and frame_sync on the first sample -> after 4th edge q=4'b1101 (ch0=1, ch3=1), out_valid=1, locked=1, slot=0.
- Hunt ignore: samples with frame_sync=0 before lock -> slot stays 0, locked=0, out_valid=0. The first frame_sync then starts the frame as above.
- Backpressure: out_ready=0 for two full frames 4'b0011 then 4'b1010 -> overrun pulses once at the second completion, q=4'b1010. Raising out_ready for 1 cycle then gives out_valid=0.
- en gaps and same-edge accept: din=0,1,1,0 with en low for 3 cycles between slots 1 and 2, and out_ready=1 at the completion edge while the previous frame is still pending -> q=4'b0110, out_valid stays 1, overrun=0.
- Resync: frame_sync asserted at slot=2 -> sync_err=1 for one cycle, slot=1 next, q unchanged. The following 3 samples 1,1,1 with sync sample 0 give q=4'b1110.
- Reset mid-frame: rst at slot=2 with out_valid=1 -> next cycle out_valid=0, q=0, locked=0. Samples without frame_sync are then ignored.

Source files
------------

// File: rtl/tdm_pkg.sv
// Shared types and helpers for the TDM receive demultiplexer.
// Constants and functions only; no logic, no latency, no flow control.
package tdm_pkg;

   typedef enum logic {
      HUNT = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam int CH_DEF = 4;
   localparam int W_DEF  = 1;

   // Bit offset of channel k inside a packed frame of w-bit channels.
   function automatic int ch_offset(input int k, input int w);
      return k * w;
   endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// Modulo-CH slot index with load-to-1 on lock/resync and terminal-count flag.
// Index is registered and updates on the edge after en/load; no backpressure.
module tdm_slot_counter #(
   parameter int CH    = 4,
   parameter int SEL_W = $clog2(CH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             load1,
   output logic [SEL_W-1:0] cnt,
   output logic             tc
);

   assign tc = (cnt == SEL_W'(CH - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (load1) begin
         cnt <= SEL_W'(1);
      end else if (en) begin
         cnt <= tc ? '0 : cnt + SEL_W'(1);
      end
   end

endmodule

// File: rtl/tdm_demux4.sv
// Receive-side 4:1 TDM demux: frame appears on q one edge after its last slot.
// Unaccepted frames are overwritten by the next completion and flagged by overrun.
module tdm_demux4
   import tdm_pkg::*;
#(
   parameter int CH    = CH_DEF,
   parameter int W     = W_DEF,
   parameter int SEL_W = $clog2(CH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [W-1:0]      din,
   input  logic              frame_sync,
   output logic [CH*W-1:0]   q,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [SEL_W-1:0]  slot,
   output logic              locked,
   output logic              sync_err,
   output logic              overrun
);

   state_t state_q, state_d;

   logic [(CH-1)*W-1:0] shadow;
   logic                tc;
   logic                sync_hit, hunt_lock, resync, advance, complete, load1;
   logic                wr_en;
   logic [SEL_W-1:0]    wr_idx;

   // A sync at slot 0 is the normal frame start and simply advances.
   always_comb begin
      sync_hit  = en & frame_sync;
      hunt_lock = (state_q == HUNT) & sync_hit;
      resync    = (state_q == RUN) & sync_hit & (slot != '0);
      advance   = (state_q == RUN) & en & ~resync;
      complete  = advance & tc;
      load1     = hunt_lock | resync;
      wr_en     = load1 | (advance & ~tc);
      wr_idx    = load1 ? '0 : slot;
   end

   always_comb begin
      state_d = state_q;
      if (hunt_lock) begin
         state_d = RUN;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= HUNT;
      end else begin
         state_q <= state_d;
      end
   end

   tdm_slot_counter #(
      .CH    (CH),
      .SEL_W (SEL_W)
   ) u_slot_counter (
      .clk   (clk),
      .rst   (rst),
      .en    (advance),
      .load1 (load1),
      .cnt   (slot),
      .tc    (tc)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         shadow <= '0;
      end else begin
         for (int k = 0; k < CH - 1; k++) begin
            if (wr_en && wr_idx == k[SEL_W-1:0]) begin
               shadow[ch_offset(k, W) +: W] <= din;
            end
         end
      end
   end

   // The last slot bypasses the shadow and lands in q on the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         q         <= '0;
         out_valid <= 1'b0;
         sync_err  <= 1'b0;
         overrun   <= 1'b0;
         locked    <= 1'b0;
      end else begin
         sync_err <= resync;
         overrun  <= complete & out_valid & ~out_ready;
         locked   <= (state_d == RUN);
         if (complete) begin
            q         <= {din, shadow};
            out_valid <= 1'b1;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_tdm_demux4.sv
// Scenario bench for tdm_demux4 (CH=4, W=1); expected frames queued as slots are driven.
module tb_tdm_demux4;

   logic       clk = 1'b0;
   logic       rst, en, din, frame_sync, out_ready;
   logic [3:0] q;
   logic       out_valid;
   logic [1:0] slot;
   logic       locked, sync_err, overrun;

   int         checks   = 0;
   int         failures = 0;
   logic [3:0] exp_q[$];
   logic [3:0] exp_frame;

   always #5 clk = ~clk;

   tdm_demux4 #(.CH(4), .W(1), .SEL_W(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .din        (din),
      .frame_sync (frame_sync),
      .q          (q),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .slot       (slot),
      .locked     (locked),
      .sync_err   (sync_err),
      .overrun    (overrun)
   );

   // Apply inputs, take one rising edge, then settle 1 time unit past it.
   task automatic drive(input logic r, input logic e, input logic d, input logic fs, input logic rdy);
      rst = r; en = e; din = d; frame_sync = fs; out_ready = rdy;
      @(posedge clk);
      #1;
   endtask

   // Four enabled slots, sync on slot 0; bits[k] is channel k.
   task automatic send_frame(input logic [3:0] bits, input logic rdy_last);
      for (int k = 0; k < 4; k++) begin
         if (k == 3) exp_q.push_back(bits);
         drive(1'b0, 1'b1, bits[k], k == 0, (k == 3) ? rdy_last : 1'b0);
      end
   endtask

   task automatic test_reset;
      drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      checks++;
      if ({q, out_valid, slot, locked, sync_err, overrun} !== 10'b0) begin
         failures++;
         $display("FAIL reset_state q=%b valid=%b slot=%0d locked=%b sync_err=%b overrun=%b, required all 0",
                  q, out_valid, slot, locked, sync_err, overrun);
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_hunt_ignore;
      for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      checks++;
      if ({slot, locked, out_valid} !== 4'b0) begin
         failures++;
         $display("FAIL hunt_ignore slot=%0d locked=%b valid=%b, required 0 0 0", slot, locked, out_valid);
      end
   endtask

   task automatic test_lock_frame;
      send_frame(4'b1101, 1'b0);
      exp_frame = exp_q.pop_front();
      checks++;
      if (q !== exp_frame) begin
         failures++;
         $display("FAIL lock_frame_q q=%b required %b", q, exp_frame);
      end
      checks++;
      if ({out_valid, locked, slot} !== 4'b1100) begin
         failures++;
         $display("FAIL lock_frame_status valid=%b locked=%b slot=%0d, required 1 1 0", out_valid, locked, slot);
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL lock_frame_accept valid=%b required 0", out_valid);
      end
   endtask

   task automatic test_backpressure;
      send_frame(4'b0011, 1'b0);
      exp_frame = exp_q.pop_front();
      checks++;
      if ({q, out_valid, overrun} !== {exp_frame, 2'b10}) begin
         failures++;
         $display("FAIL bp_first q=%b valid=%b overrun=%b, required %b 1 0", q, out_valid, overrun, exp_frame);
      end
      send_frame(4'b1010, 1'b0);
      exp_frame = exp_q.pop_front();
      checks++;
      if ({q, out_valid, overrun} !== {exp_frame, 2'b11}) begin
         failures++;
         $display("FAIL bp_overrun q=%b valid=%b overrun=%b, required %b 1 1", q, out_valid, overrun, exp_frame);
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if ({q, out_valid, overrun} !== 6'b1010_10) begin
         failures++;
         $display("FAIL bp_hold q=%b valid=%b overrun=%b, required 1010 1 0", q, out_valid, overrun);
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL bp_accept valid=%b required 0", out_valid);
      end
   endtask

   task automatic test_en_gaps;
      send_frame(4'b1111, 1'b0);
      exp_frame = exp_q.pop_front();
      checks++;
      if (q !== exp_frame) begin
         failures++;
         $display("FAIL gaps_prev_q q=%b required %b", q, exp_frame);
      end
      drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      checks++;
      if ({slot, q, out_valid} !== 7'b10_1111_1) begin
         failures++;
         $display("FAIL gaps_hold slot=%0d q=%b valid=%b, required 2 1111 1", slot, q, out_valid);
      end
      drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      exp_q.push_back(4'b0110);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      exp_frame = exp_q.pop_front();
      checks++;
      if ({q, out_valid, overrun} !== {exp_frame, 2'b10}) begin
         failures++;
         $display("FAIL gaps_same_edge q=%b valid=%b overrun=%b, required %b 1 0", q, out_valid, overrun, exp_frame);
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_resync;
      drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      checks++;
      if ({sync_err, slot, q, out_valid} !== 8'b1_01_0110_0) begin
         failures++;
         $display("FAIL resync_pulse sync_err=%b slot=%0d q=%b valid=%b, required 1 1 0110 0",
                  sync_err, slot, q, out_valid);
      end
      drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      checks++;
      if ({sync_err, slot} !== 3'b0_10) begin
         failures++;
         $display("FAIL resync_one_cycle sync_err=%b slot=%0d, required 0 2", sync_err, slot);
      end
      drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      exp_q.push_back(4'b1110);
      drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      exp_frame = exp_q.pop_front();
      checks++;
      if ({q, out_valid} !== {exp_frame, 1'b1}) begin
         failures++;
         $display("FAIL resync_frame q=%b valid=%b, required %b 1", q, out_valid, exp_frame);
      end
      // Sync arriving on the last slot restarts the frame instead of completing it.
      drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      checks++;
      if ({sync_err, slot, q, out_valid, overrun} !== 9'b1_01_1110_1_0) begin
         failures++;
         $display("FAIL resync_last_slot sync_err=%b slot=%0d q=%b valid=%b overrun=%b, required 1 1 1110 1 0",
                  sync_err, slot, q, out_valid, overrun);
      end
   endtask

   task automatic test_reset_midframe;
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      checks++;
      if ({slot, out_valid} !== 3'b10_1) begin
         failures++;
         $display("FAIL midreset_pre slot=%0d valid=%b, required 2 1", slot, out_valid);
      end
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if ({out_valid, q, locked, slot} !== 8'b0) begin
         failures++;
         $display("FAIL midreset_clear valid=%b q=%b locked=%b slot=%0d, required all 0", out_valid, q, locked, slot);
      end
      for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      checks++;
      if ({locked, slot, out_valid} !== 4'b0) begin
         failures++;
         $display("FAIL midreset_hunt locked=%b slot=%0d valid=%b, required 0 0 0", locked, slot, out_valid);
      end
      send_frame(4'b0101, 1'b1);
      exp_frame = exp_q.pop_front();
      checks++;
      if ({q, out_valid, locked} !== {exp_frame, 2'b11}) begin
         failures++;
         $display("FAIL midreset_relock q=%b valid=%b locked=%b, required %b 1 1", q, out_valid, locked, exp_frame);
      end
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; din = 1'b0; frame_sync = 1'b0; out_ready = 1'b0;
      test_reset();
      test_hunt_ignore();
      test_lock_frame();
      test_backpressure();
      test_en_gaps();
      test_resync();
      test_reset_midframe();
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain pending=%0d required 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
